oam_dma: RTL and testbench

- Sprite-attribute DMA controller on the CPU clock domain (`clk_cpu`).
- A CPU write to the DMA source register (0xFF46, decoded by top) starts a copy of LEN bytes from `{src_hi, 8'h00}` into OAM at indices 0..LEN-1.
- While active it masters the source bus: top muxes `bus_addr` onto the ROM/VRAM/WRAM decode instead of `cpu.addr`. It drives a dedicated OAM write port.

---
 rtl/gb_pkg.sv | 21 ++
 rtl/oam_dma.sv | 115 +++++++++++
 tb/tb_oam_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy SoC definitions: memory-map constants and the OAM DMA state type.
package gb_pkg;

    localparam int unsigned OAM_LEN      = 160;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  ECHO_FOLD    = 8'h20;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_DELAY,
        DMA_XFER
    } dma_state_t;

    // Pages 0xE0-0xFF are echo RAM; they read back from WRAM 0xC0-0xDF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - ECHO_FOLD) : src;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies LEN bytes from page {src,00} into OAM, one byte per cycle.
// Optional macro OAM_DMA_CPU_STALL_EN blocks non-HRAM CPU accesses while the bus is owned.
module oam_dma
    import gb_pkg::*;
#(
    parameter int unsigned LEN         = OAM_LEN,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        bus_req,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    input  logic [15:0] cpu_addr,
    output logic        cpu_stall
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
    localparam logic [1:0] DLY_INIT = 2'(START_DELAY);

    dma_state_t  state_q;
    logic [7:0]  src_q;
    logic [7:0]  idx_q;
    logic [1:0]  dly_q;
    logic        bus_req_q;
    logic [15:0] bus_addr_q;
    logic        wr_pend_q;
    logic [7:0]  wr_idx_q;
    logic [7:0]  wdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DMA_IDLE;
            src_q      <= 8'hFF;
            idx_q      <= 8'h00;
            dly_q      <= 2'd0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= 16'h0000;
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= 8'h00;
            wdata_q    <= 8'h00;
        end else if (reg_we) begin
            // Restart: the read in flight this cycle is dropped, the pending write
            // already on the OAM port completes.
            src_q     <= reg_wdata;
            idx_q     <= 8'h00;
            dly_q     <= DLY_INIT;
            wr_pend_q <= 1'b0;
            if (START_DELAY == 0) begin
                state_q    <= DMA_XFER;
                bus_req_q  <= 1'b1;
                bus_addr_q <= {dma_src_page(reg_wdata), 8'h00};
            end else begin
                state_q   <= DMA_DELAY;
                bus_req_q <= 1'b0;
            end
        end else begin
            wr_pend_q <= 1'b0;
            unique case (state_q)
                DMA_IDLE: begin
                    bus_req_q <= 1'b0;
                end
                DMA_DELAY: begin
                    if (dly_q <= 2'd1) begin
                        state_q    <= DMA_XFER;
                        bus_req_q  <= 1'b1;
                        bus_addr_q <= {dma_src_page(src_q), 8'h00};
                    end else begin
                        dly_q <= dly_q - 2'd1;
                    end
                end
                DMA_XFER: begin
                    wdata_q   <= bus_rdata;
                    wr_idx_q  <= idx_q;
                    wr_pend_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q   <= DMA_IDLE;
                        bus_req_q <= 1'b0;
                    end else begin
                        idx_q      <= idx_q + 8'd1;
                        bus_addr_q <= {dma_src_page(src_q), idx_q + 8'd1};
                    end
                end
                default: begin
                    state_q   <= DMA_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign reg_rdata = src_q;
    assign busy      = (state_q != DMA_IDLE) | wr_pend_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;
    assign oam_we    = wr_pend_q;
    assign oam_addr  = wr_idx_q;
    assign oam_wdata = wdata_q;

`ifdef OAM_DMA_CPU_STALL_EN
    assign cpu_stall = bus_req_q & ~((cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI));
`else
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^cpu_addr;
    assign cpu_stall       = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: per-cycle schedule model plus directed literal checks.
module tb_oam_dma;

    localparam int SD  = 1;
    localparam int LEN = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        busy;
    logic        bus_req;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic [15:0] cpu_addr;
    logic        cpu_stall;

    int checks = 0;
    int errors = 0;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_rdata (bus_rdata),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .cpu_addr  (cpu_addr),
        .cpu_stall (cpu_stall)
    );

    always #5 clk = ~clk;

    // Source memory: page C1 holds i^5A, other pages are offset so every page differs.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
    endfunction

    function automatic logic [7:0] page_of(input logic [7:0] s);
        return (s >= 8'hE0) ? {3'b110, s[4:0]} : s;
    endfunction

    assign bus_rdata = pat(bus_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Model: the most recent trigger (cycle and source) fully determines the schedule.
    int         cyc = 0;
    int         trig = 0;
    logic [7:0] src_m = 8'h00;
    bit         act = 1'b0;
    bit         seen_rst = 1'b0;
    bit         post_rst = 1'b0;
    logic [7:0] rdata_m = 8'hFF;
    logic [15:0] hold_m = 16'h0000;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            seen_rst <= 1'b1;
            post_rst <= 1'b1;
            act      <= 1'b0;
            rdata_m  <= 8'hFF;
        end else begin
            post_rst <= 1'b0;
            if (reg_we) begin
                act     <= 1'b1;
                trig    <= cyc + 1;
                src_m   <= reg_wdata;
                rdata_m <= reg_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            int         d;
            logic       e_busy, e_req, e_we, e_stall;
            logic [7:0] e_oa, e_od, pg;
            e_busy = 1'b0;
            e_req  = 1'b0;
            e_we   = 1'b0;
            e_oa   = 8'h00;
            e_od   = 8'h00;
            if (post_rst) hold_m = 16'h0000;
            if (act) begin
                d  = cyc - trig;
                pg = page_of(src_m);
                if (d >= SD && d < SD + LEN) begin
                    e_req  = 1'b1;
                    hold_m = {pg, 8'(d - SD)};
                end
                if (d >= SD + 1 && d <= SD + LEN) begin
                    e_we = 1'b1;
                    e_oa = 8'(d - SD - 1);
                    e_od = pat({pg, e_oa});
                end
                e_busy = (d <= SD + LEN);
            end
`ifdef OAM_DMA_CPU_STALL_EN
            e_stall = e_req && !(cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE);
`else
            e_stall = 1'b0;
`endif
            check("busy", 32'(busy), 32'(e_busy));
            check("bus_req", 32'(bus_req), 32'(e_req));
            check("bus_addr", 32'(bus_addr), 32'(hold_m));
            check("oam_we", 32'(oam_we), 32'(e_we));
            if (e_we || post_rst) begin
                check("oam_addr", 32'(oam_addr), 32'(e_oa));
                check("oam_wdata", 32'(oam_wdata), 32'(e_od));
            end
            check("reg_rdata", 32'(reg_rdata), 32'(rdata_m));
            check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] v);
        reg_we    = 1'b1;
        reg_wdata = v;
        tick();
        reg_we = 1'b0;
    endtask

    initial begin
        int nreq;
        int nwe;
        rst       = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = 8'h00;
        cpu_addr  = 16'h0000;
        repeat (3) tick();
        check("lit_rst_rdata", 32'(reg_rdata), 32'hFF);
        check("lit_rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();

        // Basic copy from 0xC100
        issue(8'hC1);
        nreq = 0;
        nwe  = 0;
        for (int d = 0; d <= 165; d++) begin
            if (d > 0) tick();
            nreq += int'(bus_req);
            nwe  += int'(oam_we);
            case (d)
                0:   check("lit_delay_busy", 32'(busy), 32'h1);
                1:   check("lit_first_read", 32'(bus_addr), 32'hC100);
                2:   check("lit_w0", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_00_5A);
                7:   check("lit_w5", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_05_5F);
                161: check("lit_wlast", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_9F_C5);
                162: check("lit_busy_fall", 32'(busy), 32'h0);
                default: ;
            endcase
        end
        check("lit_req_cycles", 32'(nreq), 32'd160);
        check("lit_write_count", 32'(nwe), 32'd160);

        // Echo fold from 0xE3, with CPU address probing for the stall feature
        issue(8'hE3);
        for (int d = 0; d <= 165; d++) begin
            if (d > 0) tick();
            case (d)
                0:   check("lit_echo_rdata", 32'(reg_rdata), 32'hE3);
                1:   check("lit_echo_first", 32'(bus_addr), 32'hC300);
                9:   cpu_addr = 16'hFF90;
                10: begin
                    check("lit_stall_hram", 32'(cpu_stall), 32'h0);
                    cpu_addr = 16'hC000;
                end
`ifdef OAM_DMA_CPU_STALL_EN
                11:  check("lit_stall_wram", 32'(cpu_stall), 32'h1);
`else
                11:  check("lit_stall_wram", 32'(cpu_stall), 32'h0);
`endif
                160: check("lit_echo_last", 32'(bus_addr), 32'hC39F);
                161: check("lit_addr_hold", 32'({bus_req, bus_addr}), 32'h0_C39F);
                163: check("lit_stall_idle", 32'(cpu_stall), 32'h0);
                default: ;
            endcase
        end
        cpu_addr = 16'h0000;

        // Restart mid-transfer: 0xC0 then 0xC2 sampled 50 edges later
        issue(8'hC0);
        repeat (49) tick();
        check("lit_trailing_w", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_2F_8A);
        issue(8'hC2);
        nwe = 0;
        for (int d = 0; d <= 165; d++) begin
            if (d > 0) tick();
            nwe += int'(oam_we);
            case (d)
                0:   check("lit_restart_now", 32'({busy, oam_we, bus_req}), 32'b100);
                1:   check("lit_restart_read", 32'(bus_addr), 32'hC200);
                2:   check("lit_restart_w0", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_00_5B);
                161: check("lit_restart_wl", 32'({oam_we, oam_addr, oam_wdata}), 32'h1_9F_C4);
                162: check("lit_restart_idle", 32'(busy), 32'h0);
                default: ;
            endcase
        end
        check("lit_restart_count", 32'(nwe), 32'd160);

        // Reset mid-transfer
        issue(8'hC1);
        repeat (80) tick();
        rst = 1'b0;
        tick();
        check("lit_mid_rst", 32'({busy, oam_we, bus_req, reg_rdata}), 32'h0_FF);
        check("lit_mid_rst_addr", 32'(bus_addr), 32'h0000);
        rst = 1'b1;
        nwe = 0;
        repeat (20) begin
            tick();
            nwe += int'(oam_we) + int'(busy);
        end
        check("lit_no_writes_after_rst", 32'(nwe), 32'd0);

        // Trigger coincident with reset: reset wins
        rst       = 1'b0;
        reg_we    = 1'b1;
        reg_wdata = 8'hC5;
        tick();
        reg_we = 1'b0;
        rst    = 1'b1;
        check("lit_rst_wins_rdata", 32'(reg_rdata), 32'hFF);
        tick();
        check("lit_rst_wins_busy", 32'({busy, bus_req}), 32'h0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
